aud_sample_fifo: RTL and testbench

Sample feeder that sits directly upstream of the audio PWM stage.
- Software (through the peripheral write port) pushes 8-bit PCM samples into a small FIFO.
- A programmable sample-rate timer pops one sample per period and presents it as the PWM duty value with a one-cycle strobe.
- Replaces a fixed on-chip music ROM with a streamed source, and reports underrun and overflow.

---
 rtl/aud_sample_fifo.sv | 157 +++++++++++++++
 tb/tb_aud_sample_fifo.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/aud_sample_fifo.sv
`default_nettype none
// ============================================================================
// Module      : aud_sample_fifo
// Description : Streamed PCM sample feeder for the audio PWM stage. Software
//               pushes samples into a small FIFO; a programmable sample-rate
//               timer pops one sample per period and presents it as the PWM
//               duty value with a one-cycle strobe. Sticky underrun/overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module aud_sample_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int DIV_WIDTH  = 16,
    parameter int LOW_WATER  = 4,
    parameter int MIDSCALE   = 128
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     enable,
    input  logic                     clr,
    input  logic [DIV_WIDTH-1:0]     div,
    input  logic                     wr_en,
    input  logic [DATA_WIDTH-1:0]    wr_data,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic [DATA_WIDTH-1:0]    sample_out,
    output logic                     sample_strobe,
    output logic                     underrun,
    output logic                     overflow
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_LVL_W = c_PTR_W + 1;
    localparam logic [c_LVL_W-1:0]    c_DEPTH_L = c_LVL_W'(DEPTH);
    localparam logic [c_LVL_W-1:0]    c_LOW_L   = c_LVL_W'(LOW_WATER);
    localparam logic [DATA_WIDTH-1:0] c_MID     = DATA_WIDTH'(MIDSCALE);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [DIV_WIDTH-1:0]    r_cnt;
    logic [c_PTR_W-1:0]      r_wptr;
    logic [c_PTR_W-1:0]      r_rptr;
    logic [c_LVL_W-1:0]      r_level;
    logic [DATA_WIDTH-1:0]   r_mem [DEPTH];
    logic [DATA_WIDTH-1:0]   r_sample;
    logic                    r_strobe;
    logic                    r_underrun;
    logic                    r_overflow;

    logic                    w_run;
    logic                    w_tick;
    logic                    w_pop;
    logic                    w_push;
    logic                    w_full;
    logic                    w_empty;

    // Status flags derive purely from the entry count.
    assign w_full  = (r_level == c_DEPTH_L);
    assign w_empty = (r_level == '0);

    // Running means in RUN and not leaving it this cycle; clr kills the tick.
    assign w_run  = (r_state == S_RUN) && enable;
    assign w_tick = w_run && (r_cnt >= div) && !clr;
    assign w_pop  = w_tick && !w_empty;
    // A pop frees a slot in the same cycle, so a full FIFO still accepts.
    assign w_push = wr_en && !clr && (!w_full || w_pop);

    // Next-state logic for the IDLE/RUN controller.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (enable)  w_state_nxt = S_RUN;
            S_RUN:   if (!enable) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    // Sample-period counter: counts while running, restarts on tick or flush.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                 r_cnt <= '0;
        else if (!w_run || clr || w_tick) r_cnt <= '0;
        else                         r_cnt <= r_cnt + DIV_WIDTH'(1);
    end

    // FIFO storage; contents need no reset because level gates every read.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= wr_data;
    end

    // Pointers and level; pointer wrap is implicit since DEPTH is a power of 2.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else if (clr) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + c_PTR_W'(1);
            if (w_pop)  r_rptr <= r_rptr + c_PTR_W'(1);
            if (w_push && !w_pop)      r_level <= r_level + c_LVL_W'(1);
            else if (w_pop && !w_push) r_level <= r_level - c_LVL_W'(1);
        end
    end

    // Output duty register: silence on leaving RUN, new sample on each pop.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sample <= c_MID;
            r_strobe <= 1'b0;
        end else begin
            r_strobe <= w_pop;
            if ((r_state == S_RUN) && !enable) r_sample <= c_MID;
            else if (w_pop)                    r_sample <= r_mem[r_rptr];
        end
    end

    // Sticky error flags, cleared only by flush or reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_underrun <= 1'b0;
            r_overflow <= 1'b0;
        end else if (clr) begin
            r_underrun <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_tick && w_empty)             r_underrun <= 1'b1;
            if (wr_en && w_full && !w_pop)     r_overflow <= 1'b1;
        end
    end

    assign full          = w_full;
    assign empty         = w_empty;
    assign almost_empty  = (r_level <= c_LOW_L);
    assign level         = r_level;
    assign sample_out    = r_sample;
    assign sample_strobe = r_strobe;
    assign underrun      = r_underrun;
    assign overflow      = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_aud_sample_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_aud_sample_fifo
// Description : Scoreboard bench for aud_sample_fifo against a queue-based
//               reference model of the sample feeder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aud_sample_fifo;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        resetn;
    logic        enable, clr, wr_en;
    logic [15:0] div;
    logic [7:0]  wr_data;
    logic        full, empty, almost_empty, sample_strobe, underrun, overflow;
    logic [4:0]  level;
    logic [7:0]  sample_out;

    aud_sample_fifo dut (
        .clk(clk), .resetn(resetn), .enable(enable), .clr(clr), .div(div),
        .wr_en(wr_en), .wr_data(wr_data), .full(full), .empty(empty),
        .almost_empty(almost_empty), .level(level), .sample_out(sample_out),
        .sample_strobe(sample_strobe), .underrun(underrun), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0] lvl;
        logic       emp, ful, aemp;
        logic [7:0] so;
        logic       st, un, ov;
    } stat_t;

    stat_t exp_q[$];
    int    samp_q[$];
    int    vectors = 0;
    int    errors  = 0;
    bit    mon_on  = 0;

    // Reference model state
    int m_fifo[$];
    int m_cnt, m_sout;
    bit m_run, m_strb, m_und, m_ovf;

    function automatic stat_t model_stat();
        stat_t s;
        s.lvl  = 5'(m_fifo.size());
        s.emp  = (m_fifo.size() == 0);
        s.ful  = (m_fifo.size() == DEPTH);
        s.aemp = (m_fifo.size() <= 4);
        s.so   = 8'(m_sout);
        s.st   = m_strb;
        s.un   = m_und;
        s.ov   = m_ovf;
        return s;
    endfunction

    task automatic model_reset();
        m_fifo.delete();
        m_cnt = 0; m_sout = 128; m_run = 0; m_strb = 0; m_und = 0; m_ovf = 0;
    endtask

    // One clock: drive inputs, record expected outputs for this cycle, advance model.
    task automatic cyc(input bit en, input bit c, input bit w, input int d, input int wd);
        bit tick, was_empty;
        enable = en; clr = c; wr_en = w; div = 16'(d); wr_data = 8'(wd);
        exp_q.push_back(model_stat());
        tick      = m_run && en && (m_cnt >= d) && !c;
        was_empty = (m_fifo.size() == 0);
        m_strb    = 0;
        if (tick && !was_empty) begin
            m_sout = m_fifo.pop_front();
            samp_q.push_back(m_sout);
            m_strb = 1;
        end
        if (tick && was_empty) m_und = 1;
        if (c) begin
            m_fifo.delete(); m_und = 0; m_ovf = 0;
        end else if (w) begin
            if (m_fifo.size() < DEPTH) m_fifo.push_back(wd & 8'hFF);
            else                       m_ovf = 1;
        end
        if (!m_run) begin
            m_cnt = 0;
            if (en) m_run = 1;
        end else if (!en) begin
            m_run = 0; m_cnt = 0; m_sout = 128;
        end else if (c || tick) m_cnt = 0;
        else m_cnt++;
        @(posedge clk); #1;
    endtask

    // Monitor: per-cycle status check, plus sample values whenever strobe is high.
    initial begin
        stat_t e, a;
        int s;
        forever begin
            @(negedge clk);
            if (mon_on && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {level, empty, full, almost_empty, sample_out, sample_strobe, underrun, overflow};
                vectors++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL status @%0t: actual=%h required=%h", $time, a, e);
                end
                if (sample_strobe === 1'b1) begin
                    vectors++;
                    if (samp_q.size() == 0) begin
                        errors++;
                        $display("FAIL sample @%0t: unexpected strobe, sample_out=%h", $time, sample_out);
                    end else begin
                        s = samp_q.pop_front();
                        if (sample_out !== 8'(s)) begin
                            errors++;
                            $display("FAIL sample @%0t: actual=%h required=%h", $time, sample_out, s);
                        end
                    end
                end
            end
        end
    end

    initial begin
        int rate, d;
        resetn = 0; enable = 0; clr = 0; wr_en = 0; div = 16'd9; wr_data = 8'h00;
        model_reset();
        repeat (5) @(posedge clk);
        #1 resetn = 1; mon_on = 1;

        // Idle after reset: silence, no strobes.
        repeat (100) cyc(0, 0, 0, 9, 0);

        // Pacing: three samples at div=9, then run past them to underrun.
        cyc(0, 0, 1, 9, 'h10);
        cyc(0, 0, 1, 9, 'h20);
        cyc(0, 0, 1, 9, 'h30);
        repeat (45) cyc(1, 0, 0, 9, 0);
        cyc(1, 0, 1, 9, 'h44);
        repeat (20) cyc(1, 0, 0, 9, 0);
        cyc(1, 1, 0, 9, 0);
        cyc(0, 0, 0, 9, 0);

        // Overflow: 17 pushes while idle, then div=0 with writes held.
        for (int i = 0; i < 17; i++) cyc(0, 0, 1, 0, $urandom_range(0, 255));
        repeat (30) cyc(1, 0, 1, 0, $urandom_range(0, 255));
        repeat (20) cyc(1, 0, 0, 0, 0);

        // Empty-boundary write coinciding with a tick.
        cyc(1, 1, 0, 3, 0);
        for (int i = 0; i < 20 && !(m_run && m_cnt >= 3); i++) cyc(1, 0, 0, 3, 0);
        cyc(1, 0, 1, 3, 'h5A);
        repeat (10) cyc(1, 0, 0, 3, 0);

        // clr with a same-cycle write mid-stream, then drop enable.
        cyc(0, 1, 0, 50, 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 1, 50, 'hA0 + i);
        repeat (5) cyc(1, 0, 0, 50, 0);
        cyc(1, 1, 1, 50, 'hEE);
        repeat (3) cyc(1, 0, 0, 50, 0);
        repeat (3) cyc(0, 0, 0, 50, 0);

        // Randomized traffic with varying write rate and divider.
        d = 2;
        for (int blk = 0; blk < 15; blk++) begin
            rate = $urandom_range(10, 90);
            for (int i = 0; i < 200; i++) begin
                if ($urandom_range(0, 49) == 0) d = $urandom_range(0, 6);
                cyc($urandom_range(0, 15) != 0, $urandom_range(0, 63) == 0,
                    $urandom_range(0, 99) < rate, d, $urandom_range(0, 255));
            end
        end

        // Asynchronous reset in the middle of a cycle.
        mon_on = 0;
        #2 resetn = 0;
        #1;
        vectors++;
        if ({level, empty, full, almost_empty, sample_out, sample_strobe, underrun, overflow} !==
            {5'd0, 1'b1, 1'b0, 1'b1, 8'd128, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL async_reset: actual lvl=%0d so=%h st=%b un=%b ov=%b required lvl=0 so=80 st=0 un=0 ov=0",
                     level, sample_out, sample_strobe, underrun, overflow);
        end
        exp_q.delete(); samp_q.delete();
        model_reset();
        @(posedge clk); #1 resetn = 1; mon_on = 1;
        for (int i = 0; i < 300; i++)
            cyc($urandom_range(0, 15) != 0, 0, $urandom_range(0, 1) == 1,
                $urandom_range(0, 3), $urandom_range(0, 255));
        repeat (2) cyc(0, 0, 0, 3, 0);

        @(negedge clk);
        vectors++;
        if (samp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_strobes: actual outstanding=%0d required=0", samp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire
